// File: rtl/cnn_icb_loader_pkg.sv
// rtl/cnn_icb_loader_pkg.sv - shared widths, state encoding and helpers for the ICB operand loader
package cnn_icb_loader_pkg;

    localparam int ICB_DW = 32;
    localparam int ICB_EW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Two operands are packed per ICB word; an odd count leaves a half-used last word.
    function automatic int words_for(input int n_elem);
        return (n_elem + 1) / 2;
    endfunction

endpackage

// File: rtl/cnn_icb_loader.sv
// rtl/cnn_icb_loader.sv - pipelined ICB read engine unpacking 16-bit operands into a flat register
import cnn_icb_loader_pkg::*;

module cnn_icb_loader #(
    parameter int DATA_WIDTH = ICB_DW,
    parameter int ELEM_W     = ICB_EW,
    parameter int N_ELEM     = 49,
    parameter int MAX_OUT    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DATA_WIDTH-1:0]      base_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [N_ELEM*ELEM_W-1:0]   data_out,
    output logic                       icb_cmd_valid,
    input  logic                       icb_cmd_ready,
    output logic [DATA_WIDTH-1:0]      icb_cmd_addr,
    output logic                       icb_cmd_read,
    output logic [DATA_WIDTH-1:0]      icb_cmd_wdata,
    output logic [3:0]                 icb_cmd_wmask,
    input  logic                       icb_rsp_valid,
    output logic                       icb_rsp_ready,
    input  logic [DATA_WIDTH-1:0]      icb_rsp_rdata,
    input  logic                       icb_rsp_err,
    output logic                       mem_holdup
);

    localparam int WORDS = words_for(N_ELEM);
    localparam int CW    = $clog2(WORDS + 1);
    localparam int OW    = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [CW-1:0] LAST_C  = CW'(WORDS - 1);
    localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUT);

    state_t                     state_q, state_d;
    logic [DATA_WIDTH-1:0]      base_q, base_d;
    logic [CW-1:0]              cmd_cnt_q, cmd_cnt_d;
    logic [CW-1:0]              rsp_cnt_q, rsp_cnt_d;
    logic [OW-1:0]              out_q, out_d;
    logic                       err_flag_q, err_flag_d;
    logic                       err_out_q, err_out_d;
    logic [N_ELEM*ELEM_W-1:0]   data_q, data_d;

    logic cmd_fire;
    logic rsp_take;

    assign icb_cmd_valid = (state_q == ST_FETCH) && (cmd_cnt_q < WORDS_C) && (out_q < MAXO_C);
    assign icb_cmd_addr  = icb_cmd_valid ? (base_q + (DATA_WIDTH'(cmd_cnt_q) << 2)) : '0;
    assign icb_cmd_read  = 1'b1;
    assign icb_cmd_wdata = '0;
    assign icb_cmd_wmask = 4'h0;
    assign icb_rsp_ready = 1'b1;

    assign cmd_fire = icb_cmd_valid && icb_cmd_ready;
    // Only a response with a read actually in flight is ours; anything else is stale.
    assign rsp_take = (state_q == ST_FETCH) && icb_rsp_valid && (out_q != '0);

    assign busy       = (state_q == ST_FETCH);
    assign mem_holdup = busy;
    assign done       = (state_q == ST_DONE);
    assign err        = err_out_q;
    assign data_out   = data_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cmd_cnt_d  = cmd_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        out_d      = out_q;
        err_flag_d = err_flag_q;
        err_out_d  = err_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d     = base_addr & ~DATA_WIDTH'(3);
                    cmd_cnt_d  = '0;
                    rsp_cnt_d  = '0;
                    out_d      = '0;
                    err_flag_d = 1'b0;
                    err_out_d  = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (cmd_fire) begin
                    cmd_cnt_d = cmd_cnt_q + CW'(1);
                end
                if (rsp_take) begin
                    rsp_cnt_d  = rsp_cnt_q + CW'(1);
                    err_flag_d = err_flag_q | icb_rsp_err;
                end
                case ({cmd_fire, rsp_take})
                    2'b10:   out_d = out_q + OW'(1);
                    2'b01:   out_d = out_q - OW'(1);
                    default: out_d = out_q;
                endcase
                if (rsp_take && (rsp_cnt_q == LAST_C)) begin
                    err_out_d = err_flag_d;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response w fills elements 2w (low half) and 2w+1 (high half, if it exists).
    always_comb begin
        data_d = data_q;
        for (int w = 0; w < WORDS; w++) begin
            if (rsp_take && (rsp_cnt_q == CW'(w))) begin
                data_d[(2*w)*ELEM_W +: ELEM_W] = icb_rsp_rdata[ELEM_W-1:0];
                if (2*w + 1 < N_ELEM) begin
                    data_d[(2*w+1)*ELEM_W +: ELEM_W] = icb_rsp_rdata[2*ELEM_W-1:ELEM_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            cmd_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            out_q      <= '0;
            err_flag_q <= 1'b0;
            err_out_q  <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cmd_cnt_q  <= cmd_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            out_q      <= out_d;
            err_flag_q <= err_flag_d;
            err_out_q  <= err_out_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_cnn_icb_loader.sv
// tb/tb_cnn_icb_loader.sv - self-checking bench for the 9- and 49-operand loaders on a shared ICB model
module tb_cnn_icb_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] base = '0;
    logic        sel = 1'b0;
    logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
    logic [31:0] rsp_rdata = '0;

    logic         busy_a, done_a, err_a, cv_a, rd_a, rr_a, hold_a;
    logic [31:0]  ca_a, wd_a;
    logic [3:0]   wm_a;
    logic [143:0] do_a;
    logic         busy_b, done_b, err_b, cv_b, rd_b, rr_b, hold_b;
    logic [31:0]  ca_b, wd_b;
    logic [3:0]   wm_b;
    logic [783:0] do_b;

    cnn_icb_loader #(.DATA_WIDTH(32), .ELEM_W(16), .N_ELEM(9), .MAX_OUT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base),
        .busy(busy_a), .done(done_a), .err(err_a), .data_out(do_a),
        .icb_cmd_valid(cv_a), .icb_cmd_ready(cmd_ready && !sel), .icb_cmd_addr(ca_a),
        .icb_cmd_read(rd_a), .icb_cmd_wdata(wd_a), .icb_cmd_wmask(wm_a),
        .icb_rsp_valid(rsp_valid && !sel), .icb_rsp_ready(rr_a), .icb_rsp_rdata(rsp_rdata),
        .icb_rsp_err(rsp_err), .mem_holdup(hold_a)
    );

    cnn_icb_loader #(.DATA_WIDTH(32), .ELEM_W(16), .N_ELEM(49), .MAX_OUT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base),
        .busy(busy_b), .done(done_b), .err(err_b), .data_out(do_b),
        .icb_cmd_valid(cv_b), .icb_cmd_ready(cmd_ready && sel), .icb_cmd_addr(ca_b),
        .icb_cmd_read(rd_b), .icb_cmd_wdata(wd_b), .icb_cmd_wmask(wm_b),
        .icb_rsp_valid(rsp_valid && sel), .icb_rsp_ready(rr_b), .icb_rsp_rdata(rsp_rdata),
        .icb_rsp_err(rsp_err), .mem_holdup(hold_b)
    );

    wire        cv_m = sel ? cv_b : cv_a;
    wire [31:0] ca_m = sel ? ca_b : ca_a;

    // Memory model: in-order responses after a fixed latency.
    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } rsp_t;
    rsp_t        rq[$];
    logic [31:0] words[25];
    logic [31:0] addr_log[$];
    logic [31:0] cur_base = '0;
    logic [31:0] prev_addr = '0;
    logic        prev_stall = 1'b0;
    int nwords = 0, err_w = -1, lat = 1, rdy_mode = 0;
    int cmds = 0, rsps = 0, out_bad = 0, stab_bad = 0, max_before = 0;

    always @(negedge clk) begin : mem_model
        int          ob;
        logic [31:0] idx;
        rsp_t        e;
        ob = cmds - rsps;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_rdata = rq[0].d;
            rsp_err   = rq[0].e;
            void'(rq.pop_front());
            rsps++;
        end else begin
            rsp_valid = 1'b0;
            rsp_rdata = '0;
            rsp_err   = 1'b0;
        end
        case (rdy_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = (cyc % 2) == 0;
            default: cmd_ready = 1'($urandom_range(0, 1));
        endcase
        if (prev_stall && (!cv_m || ca_m != prev_addr)) stab_bad++;
        if (cv_m && cmd_ready) begin
            if (ob >= 2) out_bad++;
            if (ob > max_before) max_before = ob;
            addr_log.push_back(ca_m);
            idx   = (ca_m - cur_base) >> 2;
            e.d   = (idx < 32'(nwords)) ? words[idx[4:0]] : 32'hDEAD_BEEF;
            e.e   = (idx == 32'(err_w));
            e.due = cyc + lat;
            rq.push_back(e);
            cmds++;
        end
        prev_stall = cv_m && !cmd_ready;
        prev_addr  = ca_m;
    end

    task automatic check(input string tag, input logic [783:0] obs, input logic [783:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input bit s, input logic [31:0] b, input int l, input int rm,
                            input int ew, input bit fixed, input bit mid_start, input bit chk_lat);
        int n, w, scyc, dcyc;
        bit got, addr_ok;
        logic [783:0] exp;
        n = s ? 49 : 9;
        w = (n + 1) / 2;
        @(posedge clk); #1;
        sel = s; lat = l; rdy_mode = rm; err_w = ew; nwords = w;
        base = b;
        cur_base = b & 32'hFFFF_FFFC;
        for (int i = 0; i < w; i++) begin
            words[i] = fixed ? {16'(2*i + 2), 16'(2*i + 1)} : $urandom;
        end
        if (fixed) words[w-1] = 32'h0000_0009;
        addr_log.delete();
        cmds = 0; rsps = 0; out_bad = 0; stab_bad = 0; max_before = 0; prev_stall = 1'b0;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        scyc = cyc;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        check("busy_fetch", s ? busy_b : busy_a, 1);
        check("holdup_fetch", s ? hold_b : hold_a, 1);
        check("err_cleared", s ? err_b : err_a, 0);
        check("first_valid", cv_m, 1);
        check("first_addr", ca_m, cur_base);
        got = 0; dcyc = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (mid_start && k == 2) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
            end
            if (mid_start && k == 3) begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (s ? done_b : done_a) begin
                got = 1;
                dcyc = cyc;
            end
        end
        start_a = 1'b0; start_b = 1'b0;
        check("done_seen", got, 1);
        if (got) begin
            exp = '0;
            for (int k = 0; k < n; k++) begin
                exp[k*16 +: 16] = (k % 2) ? words[k/2][31:16] : words[k/2][15:0];
            end
            check("err_with_done", s ? err_b : err_a, (ew >= 0 && ew < w) ? 1 : 0);
            check("data", s ? do_b : {640'b0, do_a}, exp);
            addr_ok = (addr_log.size() == w);
            for (int i = 0; i < addr_log.size(); i++) begin
                if (addr_log[i] != cur_base + 32'(4 * i)) addr_ok = 0;
            end
            check("addr_seq", addr_ok, 1);
            check("outstanding_limit", out_bad, 0);
            check("stall_stable", stab_bad, 0);
            if (chk_lat) check("done_latency", dcyc - scyc, w + 2);
        end else begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    initial begin
        #1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {busy_a, busy_b}, 0);
        check("rst_done", {done_a, done_b}, 0);
        check("rst_err", {err_a, err_b}, 0);
        check("rst_cmd_valid", {cv_a, cv_b}, 0);
        check("rst_cmd_addr", {ca_a, ca_b}, 0);
        check("rst_data_a", do_a, 0);
        check("rst_data_b", do_b, 0);
        check("const_cmd", {rd_a, rd_b, wd_a, wd_b, wm_a, wm_b, rr_a, rr_b}, {2'b11, 72'b0, 2'b11});
        rst = 1'b0;

        // Directed 9-operand load with the reference word pattern.
        run_load(0, 32'h100, 1, 0, -1, 1, 0, 1);
        // 49 operands from an unaligned base.
        run_load(1, 32'h2003, 1, 0, -1, 0, 0, 1);
        check("last_addr_49", addr_log[addr_log.size()-1], 32'h2060);
        // Stalling command channel with a long response latency.
        run_load(0, $urandom & 32'h00FF_FFFF, 3, 1, -1, 0, 0, 0);
        check("limit_reached_a", max_before, 1);
        run_load(1, $urandom & 32'h00FF_FFFF, 3, 2, -1, 0, 0, 0);
        check("limit_reached_b", max_before, 1);

        // Error on word 2 of 5 is sticky until the next start.
        run_load(0, 32'h400, 1, 0, 2, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("err_held", err_a, 1);
        check("done_pulse_once", done_a, 0);
        // Start during FETCH is ignored, then a back-to-back load.
        run_load(0, 32'h800, 1, 0, -1, 0, 1, 1);
        run_load(0, 32'h900, 1, 0, -1, 0, 0, 1);
        run_load(1, 32'h3000, 1, 0, -1, 0, 1, 1);

        // Reset after three commands with reads still in flight.
        @(posedge clk); #1;
        sel = 1; lat = 4; rdy_mode = 0; err_w = -1; nwords = 25;
        base = 32'h5000; cur_base = 32'h5000;
        cmds = 0; rsps = 0;
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int k = 0; k < 50 && cmds < 3; k++) @(negedge clk);
        check("rst_three_cmds", cmds, 3);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("midrst_busy", busy_b, 0);
        check("midrst_done_err", {done_b, err_b}, 0);
        check("midrst_cmd", {cv_b, ca_b}, 0);
        check("midrst_data", do_b, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        check("stale_data", do_b, 0);
        check("stale_idle", {busy_b, cv_b, done_b}, 0);
        run_load(1, 32'h6000, 1, 0, -1, 0, 0, 1);

        // Randomized loads against the model.
        for (int r = 0; r < 4; r++) begin
            run_load(1'(r % 2), $urandom, $urandom_range(1, 4), 2,
                     ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4) : -1, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
